// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: issues r_en against empty, absorbs the
// one-cycle read latency in a 2-entry buffer and presents words on a valid/ready stream.
module fifo_rd_stream #(
  parameter int fifo_data_size = 16,
  parameter int burst_len      = 4,
  parameter int cnt_width      = 16
) (
  input  logic                      clk_r,
  input  logic                      rst_r,
  input  logic                      rd_go,
  input  logic                      empty,
  input  logic                      almost_empty,
  output logic                      r_en,
  input  logic [fifo_data_size-1:0] fifo_dout,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [fifo_data_size-1:0] m_data,
  output logic                      m_last,
  output logic                      busy,
  output logic                      low_water,
  output logic [cnt_width-1:0]      word_cnt
);

  localparam int beat_w = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [beat_w-1:0] beat_max = beat_w'(burst_len - 1);

  logic [1:0]                occ_reg, occ_next;
  logic                      pend_reg;
  logic [fifo_data_size-1:0] entry_reg  [0:1];
  logic [fifo_data_size-1:0] entry_next [0:1];
  logic [beat_w-1:0]         beat_reg, beat_next;
  logic [cnt_width-1:0]      word_cnt_reg;
  logic                      low_water_reg;
  logic                      pop;
  logic                      push;
  logic [2:0]                committed;

  assign pop  = m_valid & m_ready;
  assign push = pend_reg;

  // Slots already spoken for after this edge: held words plus the read in flight.
  assign committed = {1'b0, occ_reg} + {2'b00, pend_reg} - {2'b00, pop};
  assign r_en      = rst_r & rd_go & ~empty & (committed < 3'd2);

  assign m_valid   = (occ_reg != 2'd0);
  assign m_data    = entry_reg[0];
  assign m_last    = m_valid & (beat_reg == beat_max);
  assign busy      = m_valid | pend_reg;
  assign low_water = low_water_reg;
  assign word_cnt  = word_cnt_reg;

  always_comb begin
    occ_next      = occ_reg;
    entry_next[0] = entry_reg[0];
    entry_next[1] = entry_reg[1];
    case ({push, pop})
      2'b10: begin
        if (occ_reg == 2'd0) entry_next[0] = fifo_dout;
        else                 entry_next[1] = fifo_dout;
        occ_next = occ_reg + 2'd1;
      end
      2'b01: begin
        entry_next[0] = entry_reg[1];
        occ_next      = occ_reg - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the arriving word lands behind whatever survives the pop.
        if (occ_reg == 2'd1) begin
          entry_next[0] = fifo_dout;
        end else begin
          entry_next[0] = entry_reg[1];
          entry_next[1] = fifo_dout;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_next = beat_reg;
    if (pop) beat_next = (beat_reg == beat_max) ? '0 : beat_reg + beat_w'(1);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk_r or negedge rst_r) begin
        if (!rst_r) entry_reg[gi] <= '0;
        else        entry_reg[gi] <= entry_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      occ_reg       <= 2'd0;
      pend_reg      <= 1'b0;
      beat_reg      <= '0;
      word_cnt_reg  <= '0;
      low_water_reg <= 1'b0;
    end else begin
      occ_reg       <= occ_next;
      pend_reg      <= r_en;
      beat_reg      <= beat_next;
      low_water_reg <= almost_empty;
      if (pop) word_cnt_reg <= word_cnt_reg + cnt_width'(1);
    end
  end

endmodule
